// File: rtl/calc_sequencer_if.sv
// Handshake and ALU bus bundle for calc_sequencer.
// master = sequencer side, slave = upstream/downstream/ALU environment side.
interface calc_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [2:0] alu_op;
    logic [4:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic       busy;

    modport master (
        input  in_valid, in_data, alu_result, out_ready,
        output in_ready, alu_A, alu_B, alu_op, out_valid, out_result, busy
    );

    modport slave (
        output in_valid, in_data, alu_result, out_ready,
        input  in_ready, alu_A, alu_B, alu_op, out_valid, out_result, busy
    );
endinterface

// File: rtl/calc_sequencer.sv
// Operand/opcode sequencer for an external combinational ALU with a timed result capture.
// Optional macro CALC_ACCUM_EN: chain each accepted result into operand A and add the clr input.
module calc_sequencer #(
    parameter int unsigned EXEC_WAIT = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CALC_ACCUM_EN
    input  logic clr,
`endif
    calc_sequencer_if.master bus
);

    typedef enum logic [2:0] {S_A, S_B, S_OP, EXEC, OUT} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [4:0] res_q, res_d;
    logic       ov_q, ov_d;
    logic       in_ready_s;
    logic       busy_s;
    logic       in_fire;
    logic       clr_in;

`ifdef CALC_ACCUM_EN
    assign clr_in = clr;
`else
    assign clr_in = 1'b0;
`endif

    assign in_fire = bus.in_valid & in_ready_s;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:  if (in_fire) state_d = S_B;
            S_B: begin
                if (clr_in)       state_d = S_A;
                else if (in_fire) state_d = S_OP;
            end
            S_OP: if (in_fire) state_d = EXEC;
            EXEC: if (cnt_q == 4'd1) state_d = OUT;
            OUT: begin
                if (bus.out_ready) begin
`ifdef CALC_ACCUM_EN
                    state_d = S_B;
`else
                    state_d = S_A;
`endif
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        in_ready_s = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
        busy_s     = (state_q == EXEC) || (state_q == OUT);
    end

    // Operands and opcode only change on input transfers, so the ALU sees stable inputs through EXEC/OUT.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        res_d = res_q;
        ov_d  = ov_q;
        case (state_q)
            S_A:  if (in_fire) a_d = bus.in_data;
            S_B:  if (in_fire && !clr_in) b_d = bus.in_data;
            S_OP: begin
                if (in_fire) begin
                    op_d  = bus.in_data[2:0];
                    cnt_d = 4'(EXEC_WAIT);
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d = bus.alu_result;
                    ov_d  = 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    ov_d = 1'b0;
`ifdef CALC_ACCUM_EN
                    a_d  = res_q[3:0];
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '1;
            cnt_q <= '0;
            res_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.busy       = busy_s;
    assign bus.alu_A      = a_q;
    assign bus.alu_B      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_result = res_q;

endmodule
